// File: rtl/ctrl_pipeline.sv
// Control-side pipeline registers (ID/EX, EX/MEM, MEM/WB) for the 5-stage core.
// Inserts bubbles on load-use hazards and taken transfers, honours hold and drives the EX forwarding selects.
module ctrl_pipeline #(
   parameter int REG_ADDR_W = 5
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  id_valid,
   input  logic                  id_alu_src,
   input  logic [1:0]            id_wb_data_src,
   input  logic                  id_reg_write,
   input  logic                  id_mem_read,
   input  logic                  id_mem_write,
   input  logic [1:0]            id_alu_op,
   input  logic [1:0]            id_ctrl_transfer,
   input  logic [REG_ADDR_W-1:0] id_rs1,
   input  logic [REG_ADDR_W-1:0] id_rs2,
   input  logic [REG_ADDR_W-1:0] id_rd,
   input  logic                  ex_flush,
   input  logic                  hold,
   output logic                  ex_alu_src,
   output logic [1:0]            ex_alu_op,
   output logic [1:0]            ex_ctrl_transfer,
   output logic                  ex_mem_read,
   output logic                  ex_mem_write,
   output logic [1:0]            ex_wb_data_src,
   output logic                  ex_reg_write,
   output logic [REG_ADDR_W-1:0] ex_rd,
   output logic                  ex_valid,
   output logic                  mem_mem_read,
   output logic                  mem_mem_write,
   output logic [1:0]            mem_wb_data_src,
   output logic                  mem_reg_write,
   output logic [REG_ADDR_W-1:0] mem_rd,
   output logic                  mem_valid,
   output logic [1:0]            wb_wb_data_src,
   output logic                  wb_reg_write,
   output logic [REG_ADDR_W-1:0] wb_rd,
   output logic                  wb_valid,
   output logic [1:0]            forward_a,
   output logic [1:0]            forward_b,
   output logic                  pc_write,
   output logic                  ifid_write,
   output logic                  ifid_flush
);

   localparam logic [REG_ADDR_W-1:0] REG_ZERO = {REG_ADDR_W{1'b0}};

   logic                  ex_alu_src_q, ex_alu_src_d;
   logic [1:0]            ex_alu_op_q, ex_alu_op_d;
   logic [1:0]            ex_ctrl_transfer_q, ex_ctrl_transfer_d;
   logic                  ex_mem_read_q, ex_mem_read_d;
   logic                  ex_mem_write_q, ex_mem_write_d;
   logic [1:0]            ex_wb_data_src_q, ex_wb_data_src_d;
   logic                  ex_reg_write_q, ex_reg_write_d;
   logic [REG_ADDR_W-1:0] ex_rd_q, ex_rd_d;
   logic [REG_ADDR_W-1:0] ex_rs1_q, ex_rs1_d;
   logic [REG_ADDR_W-1:0] ex_rs2_q, ex_rs2_d;
   logic                  ex_valid_q, ex_valid_d;
   logic                  mem_mem_read_q, mem_mem_read_d;
   logic                  mem_mem_write_q, mem_mem_write_d;
   logic [1:0]            mem_wb_data_src_q, mem_wb_data_src_d;
   logic                  mem_reg_write_q, mem_reg_write_d;
   logic [REG_ADDR_W-1:0] mem_rd_q, mem_rd_d;
   logic                  mem_valid_q, mem_valid_d;
   logic [1:0]            wb_wb_data_src_q, wb_wb_data_src_d;
   logic                  wb_reg_write_q, wb_reg_write_d;
   logic [REG_ADDR_W-1:0] wb_rd_q, wb_rd_d;
   logic                  wb_valid_q, wb_valid_d;
   logic                  load_use_s;

   function automatic logic [1:0] fwd_sel(
      input logic [REG_ADDR_W-1:0] rs,
      input logic                  m_rw,
      input logic [REG_ADDR_W-1:0] m_rd,
      input logic                  w_rw,
      input logic [REG_ADDR_W-1:0] w_rd
   );
      if (m_rw && (m_rd != REG_ZERO) && (m_rd == rs)) begin
         return 2'b10;
      end else if (w_rw && (w_rd != REG_ZERO) && (w_rd == rs)) begin
         return 2'b01;
      end else begin
         return 2'b00;
      end
   endfunction

   assign load_use_s = id_valid && ex_valid_q && ex_mem_read_q && (ex_rd_q != REG_ZERO) &&
                       ((ex_rd_q == id_rs1) || (ex_rd_q == id_rs2));

   // Next state: hold freezes everything; otherwise MEM/WB shift and EX takes ID or a bubble.
   always_comb begin
      ex_alu_src_d       = ex_alu_src_q;
      ex_alu_op_d        = ex_alu_op_q;
      ex_ctrl_transfer_d = ex_ctrl_transfer_q;
      ex_mem_read_d      = ex_mem_read_q;
      ex_mem_write_d     = ex_mem_write_q;
      ex_wb_data_src_d   = ex_wb_data_src_q;
      ex_reg_write_d     = ex_reg_write_q;
      ex_rd_d            = ex_rd_q;
      ex_rs1_d           = ex_rs1_q;
      ex_rs2_d           = ex_rs2_q;
      ex_valid_d         = ex_valid_q;
      mem_mem_read_d     = mem_mem_read_q;
      mem_mem_write_d    = mem_mem_write_q;
      mem_wb_data_src_d  = mem_wb_data_src_q;
      mem_reg_write_d    = mem_reg_write_q;
      mem_rd_d           = mem_rd_q;
      mem_valid_d        = mem_valid_q;
      wb_wb_data_src_d   = wb_wb_data_src_q;
      wb_reg_write_d     = wb_reg_write_q;
      wb_rd_d            = wb_rd_q;
      wb_valid_d         = wb_valid_q;
      if (!hold) begin
         mem_mem_read_d    = ex_mem_read_q;
         mem_mem_write_d   = ex_mem_write_q;
         mem_wb_data_src_d = ex_wb_data_src_q;
         mem_reg_write_d   = ex_reg_write_q;
         mem_rd_d          = ex_rd_q;
         mem_valid_d       = ex_valid_q;
         wb_wb_data_src_d  = mem_wb_data_src_q;
         wb_reg_write_d    = mem_reg_write_q;
         wb_rd_d           = mem_rd_q;
         wb_valid_d        = mem_valid_q;
         // A killed, stalled or empty ID slot becomes a bubble, including its source indices.
         if (ex_flush || load_use_s || !id_valid) begin
            ex_alu_src_d       = 1'b0;
            ex_alu_op_d        = 2'b00;
            ex_ctrl_transfer_d = 2'b00;
            ex_mem_read_d      = 1'b0;
            ex_mem_write_d     = 1'b0;
            ex_wb_data_src_d   = 2'b00;
            ex_reg_write_d     = 1'b0;
            ex_rd_d            = REG_ZERO;
            ex_rs1_d           = REG_ZERO;
            ex_rs2_d           = REG_ZERO;
            ex_valid_d         = 1'b0;
         end else begin
            ex_alu_src_d       = id_alu_src;
            ex_alu_op_d        = id_alu_op;
            ex_ctrl_transfer_d = id_ctrl_transfer;
            ex_mem_read_d      = id_mem_read;
            ex_mem_write_d     = id_mem_write;
            ex_wb_data_src_d   = id_wb_data_src;
            ex_reg_write_d     = id_reg_write && (id_rd != REG_ZERO);
            ex_rd_d            = id_rd;
            ex_rs1_d           = id_rs1;
            ex_rs2_d           = id_rs2;
            ex_valid_d         = 1'b1;
         end
      end else begin
         ex_valid_d = ex_valid_q;
      end
   end

   // Stage registers with synchronous active-low clear.
   always_ff @(posedge clk) begin
      if (!reset) begin
         ex_alu_src_q       <= 1'b0;
         ex_alu_op_q        <= 2'b00;
         ex_ctrl_transfer_q <= 2'b00;
         ex_mem_read_q      <= 1'b0;
         ex_mem_write_q     <= 1'b0;
         ex_wb_data_src_q   <= 2'b00;
         ex_reg_write_q     <= 1'b0;
         ex_rd_q            <= REG_ZERO;
         ex_rs1_q           <= REG_ZERO;
         ex_rs2_q           <= REG_ZERO;
         ex_valid_q         <= 1'b0;
         mem_mem_read_q     <= 1'b0;
         mem_mem_write_q    <= 1'b0;
         mem_wb_data_src_q  <= 2'b00;
         mem_reg_write_q    <= 1'b0;
         mem_rd_q           <= REG_ZERO;
         mem_valid_q        <= 1'b0;
         wb_wb_data_src_q   <= 2'b00;
         wb_reg_write_q     <= 1'b0;
         wb_rd_q            <= REG_ZERO;
         wb_valid_q         <= 1'b0;
      end else begin
         ex_alu_src_q       <= ex_alu_src_d;
         ex_alu_op_q        <= ex_alu_op_d;
         ex_ctrl_transfer_q <= ex_ctrl_transfer_d;
         ex_mem_read_q      <= ex_mem_read_d;
         ex_mem_write_q     <= ex_mem_write_d;
         ex_wb_data_src_q   <= ex_wb_data_src_d;
         ex_reg_write_q     <= ex_reg_write_d;
         ex_rd_q            <= ex_rd_d;
         ex_rs1_q           <= ex_rs1_d;
         ex_rs2_q           <= ex_rs2_d;
         ex_valid_q         <= ex_valid_d;
         mem_mem_read_q     <= mem_mem_read_d;
         mem_mem_write_q    <= mem_mem_write_d;
         mem_wb_data_src_q  <= mem_wb_data_src_d;
         mem_reg_write_q    <= mem_reg_write_d;
         mem_rd_q           <= mem_rd_d;
         mem_valid_q        <= mem_valid_d;
         wb_wb_data_src_q   <= wb_wb_data_src_d;
         wb_reg_write_q     <= wb_reg_write_d;
         wb_rd_q            <= wb_rd_d;
         wb_valid_q         <= wb_valid_d;
      end
   end

   // Fetch-side control: hold wins, a taken transfer refetches, a load-use stalls one cycle.
   always_comb begin
      pc_write   = 1'b1;
      ifid_write = 1'b1;
      ifid_flush = 1'b0;
      if (hold) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         ifid_flush = 1'b0;
      end else if (ex_flush) begin
         pc_write   = 1'b1;
         ifid_write = 1'b1;
         ifid_flush = 1'b1;
      end else if (load_use_s) begin
         pc_write   = 1'b0;
         ifid_write = 1'b0;
         ifid_flush = 1'b0;
      end else begin
         pc_write   = 1'b1;
         ifid_write = 1'b1;
         ifid_flush = 1'b0;
      end
   end

   assign forward_a = fwd_sel(ex_rs1_q, mem_reg_write_q, mem_rd_q, wb_reg_write_q, wb_rd_q);
   assign forward_b = fwd_sel(ex_rs2_q, mem_reg_write_q, mem_rd_q, wb_reg_write_q, wb_rd_q);

   assign ex_alu_src       = ex_alu_src_q;
   assign ex_alu_op        = ex_alu_op_q;
   assign ex_ctrl_transfer = ex_ctrl_transfer_q;
   assign ex_mem_read      = ex_mem_read_q;
   assign ex_mem_write     = ex_mem_write_q;
   assign ex_wb_data_src   = ex_wb_data_src_q;
   assign ex_reg_write     = ex_reg_write_q;
   assign ex_rd            = ex_rd_q;
   assign ex_valid         = ex_valid_q;
   assign mem_mem_read     = mem_mem_read_q;
   assign mem_mem_write    = mem_mem_write_q;
   assign mem_wb_data_src  = mem_wb_data_src_q;
   assign mem_reg_write    = mem_reg_write_q;
   assign mem_rd           = mem_rd_q;
   assign mem_valid        = mem_valid_q;
   assign wb_wb_data_src   = wb_wb_data_src_q;
   assign wb_reg_write     = wb_reg_write_q;
   assign wb_rd            = wb_rd_q;
   assign wb_valid         = wb_valid_q;

endmodule

// File: tb/tb_ctrl_pipeline.sv
// Bench for ctrl_pipeline: directed vector table for hazard corners, then random traffic against a stage-list model.
module tb_ctrl_pipeline;
   localparam int W = 5;

   logic clk = 1'b0;
   logic reset, id_valid, id_alu_src, id_reg_write, id_mem_read, id_mem_write, ex_flush, hold;
   logic [1:0] id_wb_data_src, id_alu_op, id_ctrl_transfer;
   logic [W-1:0] id_rs1, id_rs2, id_rd;
   logic ex_alu_src, ex_mem_read, ex_mem_write, ex_reg_write, ex_valid;
   logic [1:0] ex_alu_op, ex_ctrl_transfer, ex_wb_data_src;
   logic [W-1:0] ex_rd, mem_rd, wb_rd;
   logic mem_mem_read, mem_mem_write, mem_reg_write, mem_valid, wb_reg_write, wb_valid;
   logic [1:0] mem_wb_data_src, wb_wb_data_src, forward_a, forward_b;
   logic pc_write, ifid_write, ifid_flush;

   int errors = 0;
   int checks = 0;

   always #5 clk = ~clk;

   ctrl_pipeline #(.REG_ADDR_W(W)) dut (
      .clk(clk), .reset(reset), .id_valid(id_valid), .id_alu_src(id_alu_src),
      .id_wb_data_src(id_wb_data_src), .id_reg_write(id_reg_write), .id_mem_read(id_mem_read),
      .id_mem_write(id_mem_write), .id_alu_op(id_alu_op), .id_ctrl_transfer(id_ctrl_transfer),
      .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd), .ex_flush(ex_flush), .hold(hold),
      .ex_alu_src(ex_alu_src), .ex_alu_op(ex_alu_op), .ex_ctrl_transfer(ex_ctrl_transfer),
      .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_wb_data_src(ex_wb_data_src),
      .ex_reg_write(ex_reg_write), .ex_rd(ex_rd), .ex_valid(ex_valid),
      .mem_mem_read(mem_mem_read), .mem_mem_write(mem_mem_write), .mem_wb_data_src(mem_wb_data_src),
      .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_valid(mem_valid),
      .wb_wb_data_src(wb_wb_data_src), .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_valid(wb_valid),
      .forward_a(forward_a), .forward_b(forward_b), .pc_write(pc_write),
      .ifid_write(ifid_write), .ifid_flush(ifid_flush)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- directed vectors ----------------
   typedef struct {
      logic chk;
      logic rst, hld, fl, v, rw, mr, mw;
      logic [W-1:0] rs1, rs2, rd;
      logic pc, ifw, ifl;
      logic [1:0] fa, fb;
      logic exv, exrw, exmw, memv, memmw, wbv;
   } vec_t;

   vec_t tbl[23];

   function automatic vec_t mk(input logic chk, rst, hld, fl, v, rw, mr, mw,
                               input int rs1, rs2, rd,
                               input logic pc, ifw, ifl, input int fa, fb,
                               input logic exv, exrw, exmw, memv, memmw, wbv);
      vec_t t;
      t.chk = chk; t.rst = rst; t.hld = hld; t.fl = fl; t.v = v; t.rw = rw; t.mr = mr; t.mw = mw;
      t.rs1 = W'(rs1); t.rs2 = W'(rs2); t.rd = W'(rd);
      t.pc = pc; t.ifw = ifw; t.ifl = ifl; t.fa = 2'(fa); t.fb = 2'(fb);
      t.exv = exv; t.exrw = exrw; t.exmw = exmw; t.memv = memv; t.memmw = memmw; t.wbv = wbv;
      return t;
   endfunction

   // ---------------- reference model ----------------
   typedef struct {
      logic v, alu_src, rw, mr, mw;
      logic [1:0] wbs, aop, ct;
      logic [W-1:0] rs1, rs2, rd;
   } ins_t;

   ins_t st[3];   // 0: EX, 1: MEM, 2: WB

   function automatic ins_t bubble();
      ins_t b;
      b.v = 1'b0; b.alu_src = 1'b0; b.rw = 1'b0; b.mr = 1'b0; b.mw = 1'b0;
      b.wbs = 2'b00; b.aop = 2'b00; b.ct = 2'b00; b.rs1 = '0; b.rs2 = '0; b.rd = '0;
      return b;
   endfunction

   // Nearest older producer of r (MEM before WB) decides the forward source.
   function automatic logic [1:0] ref_fwd(input logic [W-1:0] r);
      if (r == 0) return 2'b00;
      for (int s = 1; s <= 2; s++)
         if (st[s].rw && st[s].rd == r) return (s == 1) ? 2'b10 : 2'b01;
      return 2'b00;
   endfunction

   function automatic logic ref_load_use();
      return id_valid && st[0].v && st[0].mr && st[0].rd != 0 &&
             (st[0].rd == id_rs1 || st[0].rd == id_rs2);
   endfunction

   task automatic model_edge();
      ins_t n;
      if (!reset) begin
         for (int s = 0; s < 3; s++) st[s] = bubble();
      end else if (!hold) begin
         n = bubble();
         if (id_valid && !ex_flush && !ref_load_use()) begin
            n.v = 1'b1; n.alu_src = id_alu_src; n.rw = id_reg_write && id_rd != 0;
            n.mr = id_mem_read; n.mw = id_mem_write; n.wbs = id_wb_data_src;
            n.aop = id_alu_op; n.ct = id_ctrl_transfer; n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd;
         end
         st[2] = st[1];
         st[1] = st[0];
         st[0] = n;
      end
   endtask

   function automatic logic [63:0] dut_vec();
      return {21'd0, ex_alu_src, ex_alu_op, ex_ctrl_transfer, ex_mem_read, ex_mem_write, ex_wb_data_src,
              ex_reg_write, ex_rd, ex_valid, mem_mem_read, mem_mem_write, mem_wb_data_src, mem_reg_write,
              mem_rd, mem_valid, wb_wb_data_src, wb_reg_write, wb_rd, wb_valid, forward_a, forward_b,
              pc_write, ifid_write, ifid_flush};
   endfunction

   function automatic logic [63:0] ref_vec();
      logic pc, ifw, ifl, lu;
      lu = ref_load_use();
      pc  = !hold && (ex_flush || !lu);
      ifw = pc;
      ifl = !hold && ex_flush;
      return {21'd0, st[0].alu_src, st[0].aop, st[0].ct, st[0].mr, st[0].mw, st[0].wbs,
              st[0].rw, st[0].rd, st[0].v, st[1].mr, st[1].mw, st[1].wbs, st[1].rw,
              st[1].rd, st[1].v, st[2].wbs, st[2].rw, st[2].rd, st[2].v,
              ref_fwd(st[0].rs1), ref_fwd(st[0].rs2), pc, ifw, ifl};
   endfunction

   initial begin
      for (int s = 0; s < 3; s++) st[s] = bubble();
      //            chk r h f v rw mr mw rs1 rs2 rd  pc ifw ifl fa fb exv exrw exmw memv memmw wbv
      tbl[0]  = mk(0, 0,0,0,1,1,1,0, 1, 0, 5,  1,1,0, 0,0, 0,0,0,0,0,0);
      tbl[1]  = mk(1, 0,0,0,1,1,1,0, 1, 0, 5,  1,1,0, 0,0, 0,0,0,0,0,0);
      tbl[2]  = mk(1, 1,0,0,1,1,1,0, 1, 0, 5,  1,1,0, 0,0, 0,0,0,0,0,0);  // lw x5
      tbl[3]  = mk(1, 1,0,0,1,1,0,0, 5, 6, 7,  0,0,0, 0,0, 1,1,0,0,0,0);  // add rs1=5: stall
      tbl[4]  = mk(1, 1,0,0,1,1,0,0, 5, 6, 7,  1,1,0, 0,0, 0,0,0,1,0,0);  // bubble in EX
      tbl[5]  = mk(1, 1,0,0,1,1,0,0, 1, 2, 3,  1,1,0, 1,0, 1,1,0,0,0,1);  // add in EX, lw in WB
      tbl[6]  = mk(1, 1,0,0,1,1,0,0, 4, 3, 8,  1,1,0, 0,0, 1,1,0,1,0,0);  // sub rs2=3
      tbl[7]  = mk(1, 1,0,0,1,1,0,0, 3, 9,10,  1,1,0, 0,2, 1,1,0,1,0,1);  // add rs1=3
      tbl[8]  = mk(1, 1,0,1,1,0,0,1, 2,11, 0,  1,1,1, 1,0, 1,1,0,1,0,1);  // flush kills store
      tbl[9]  = mk(1, 1,0,0,0,0,0,0, 0, 0, 0,  1,1,0, 0,0, 0,0,0,1,0,1);
      tbl[10] = mk(1, 1,0,0,0,0,0,0, 0, 0, 0,  1,1,0, 0,0, 0,0,0,0,0,1);
      tbl[11] = mk(1, 1,0,0,1,1,0,0, 1, 2,12,  1,1,0, 0,0, 0,0,0,0,0,0);
      tbl[12] = mk(1, 1,1,1,1,1,0,0,12, 0,13,  0,0,0, 0,0, 1,1,0,0,0,0);  // hold with flush
      tbl[13] = mk(1, 1,1,1,1,1,0,0,12, 0,13,  0,0,0, 0,0, 1,1,0,0,0,0);
      tbl[14] = mk(1, 1,1,1,1,1,0,0,12, 0,13,  0,0,0, 0,0, 1,1,0,0,0,0);
      tbl[15] = mk(1, 1,0,1,1,1,0,0,12, 0,13,  1,1,1, 0,0, 1,1,0,0,0,0);  // flush once
      tbl[16] = mk(1, 1,0,0,0,0,0,0, 0, 0, 0,  1,1,0, 0,0, 0,0,0,1,0,0);
      tbl[17] = mk(1, 1,0,0,0,0,0,0, 0, 0, 0,  1,1,0, 0,0, 0,0,0,0,0,1);
      tbl[18] = mk(1, 1,0,0,1,1,1,0, 1, 2, 0,  1,1,0, 0,0, 0,0,0,0,0,0);  // load to x0
      tbl[19] = mk(1, 1,0,0,1,1,0,0, 0, 0,14,  1,1,0, 0,0, 1,0,0,0,0,0);  // no stall on x0
      tbl[20] = mk(1, 1,0,0,0,0,0,0, 0, 0, 0,  1,1,0, 0,0, 1,1,0,1,0,0);
      tbl[21] = mk(1, 0,0,0,1,1,0,0, 1, 2, 3,  1,1,0, 0,0, 0,0,0,1,0,1);  // reset mid-stream
      tbl[22] = mk(1, 1,0,0,0,0,0,0, 0, 0, 0,  1,1,0, 0,0, 0,0,0,0,0,0);

      id_alu_src = 1'b0; id_wb_data_src = 2'b01; id_alu_op = 2'b01; id_ctrl_transfer = 2'b00;
      for (int i = 0; i < 23; i++) begin
         @(negedge clk);
         reset = tbl[i].rst; hold = tbl[i].hld; ex_flush = tbl[i].fl; id_valid = tbl[i].v;
         id_reg_write = tbl[i].rw; id_mem_read = tbl[i].mr; id_mem_write = tbl[i].mw;
         id_rs1 = tbl[i].rs1; id_rs2 = tbl[i].rs2; id_rd = tbl[i].rd;
         #1;
         if (tbl[i].chk) begin
            check($sformatf("vec%0d_ctl", i), {61'd0, pc_write, ifid_write, ifid_flush},
                  {61'd0, tbl[i].pc, tbl[i].ifw, tbl[i].ifl});
            check($sformatf("vec%0d_fwd", i), {60'd0, forward_a, forward_b}, {60'd0, tbl[i].fa, tbl[i].fb});
            check($sformatf("vec%0d_stage", i),
                  {58'd0, ex_valid, ex_reg_write, ex_mem_write, mem_valid, mem_mem_write, wb_valid},
                  {58'd0, tbl[i].exv, tbl[i].exrw, tbl[i].exmw, tbl[i].memv, tbl[i].memmw, tbl[i].wbv});
         end
      end

      // Random traffic; state is cleared at this point so the model starts from bubbles.
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         reset = ($urandom_range(0, 49) != 0);
         hold = ($urandom_range(0, 5) == 0);
         ex_flush = ($urandom_range(0, 5) == 0);
         id_valid = ($urandom_range(0, 3) != 0);
         id_alu_src = 1'($urandom); id_wb_data_src = 2'($urandom); id_reg_write = 1'($urandom);
         id_mem_read = ($urandom_range(0, 2) == 0); id_mem_write = 1'($urandom);
         id_alu_op = 2'($urandom); id_ctrl_transfer = 2'($urandom);
         id_rs1 = W'($urandom_range(0, 7)); id_rs2 = W'($urandom_range(0, 7)); id_rd = W'($urandom_range(0, 7));
         #1;
         check($sformatf("rand%0d", c), dut_vec(), ref_vec());
         @(posedge clk);
         model_edge();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
